// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop input synchroniser, start-bit false-start check,
// mid-bit sampling, valid/ack holding register, framing/overrun error pulses.
module uart_rx #(
  parameter int unsigned BAUD_DIV = 217
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  input  logic       i_ack,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_overrun
);

  localparam logic [15:0] BaudCnt = 16'(BAUD_DIV);
  localparam logic [15:0] HalfCnt = 16'(BAUD_DIV / 2);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StStart    = 3'd1,
    StData     = 3'd2,
    StStop     = 3'd3,
    StWaitHigh = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic        sync1_q;
  logic        rx_s_q;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q, overrun_d;

  logic        rx_s;
  logic        baud_full;
  logic        baud_half;
  logic        byte_done;

  assign rx_s      = rx_s_q;
  assign baud_full = (baud_cnt_q == BaudCnt);
  assign baud_half = (baud_cnt_q == HalfCnt);

  // State register, synchroniser and datapath flops (synchronous active-low reset).
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q     <= StIdle;
      sync1_q     <= 1'b1;
      rx_s_q      <= 1'b1;
      baud_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= i_rx;
      rx_s_q      <= sync1_q;
      baud_cnt_q  <= baud_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (!rx_s) state_d = StStart;
      end
      StStart: begin
        if (baud_half) state_d = rx_s ? StIdle : StData;
      end
      StData: begin
        if (baud_full && (bit_cnt_q == 4'd7)) state_d = StStop;
      end
      StStop: begin
        // Leave at mid-stop-bit so an immediately following start edge is caught.
        if (baud_full) state_d = rx_s ? StIdle : StWaitHigh;
      end
      StWaitHigh: begin
        if (rx_s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Counters, shift register and registered outputs.
  always_comb begin
    baud_cnt_d  = baud_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    byte_done   = 1'b0;

    case (state_q)
      StIdle: begin
        if (!rx_s) baud_cnt_d = 16'd1;
      end
      StStart: begin
        if (baud_half) begin
          if (!rx_s) begin
            baud_cnt_d = 16'd1;
            bit_cnt_d  = 4'd0;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
      StData: begin
        if (baud_full) begin
          shift_d    = {rx_s, shift_q[7:1]};
          bit_cnt_d  = bit_cnt_q + 4'd1;
          baud_cnt_d = 16'd1;
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
      StStop: begin
        if (baud_full) begin
          if (rx_s) byte_done = 1'b1;
          else      frame_err_d = 1'b1;
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
      default: ;
    endcase

    // A completing byte wins over a same-cycle ack; only an unacked one overruns.
    if (byte_done) begin
      data_d    = shift_q;
      valid_d   = 1'b1;
      overrun_d = valid_q & ~i_ack;
    end else if (valid_q && i_ack) begin
      valid_d = 1'b0;
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = frame_err_q;
  assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at BAUD_DIV=8, with a behavioural
// serialiser driving the line and a monitor counting output events.
module tb_uart_rx;

  localparam int unsigned Baud = 8;

  logic       clk;
  logic       rst;
  logic       rx;
  logic       ack_man;
  logic       ack_auto;
  logic       ack;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;

  int total = 0;
  int bad   = 0;

  int cyc = 0;
  int start_cyc = 0;
  int rise_cyc = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int rise_cnt = 0;
  int vcnt = 0;
  logic auto_en = 1'b0;
  logic valid_prev = 1'b0;
  logic [7:0] cap [0:15];

  assign ack = ack_man | ack_auto;

  uart_rx #(.BAUD_DIV(Baud)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_rx       (rx),
    .i_ack      (ack),
    .o_data     (data),
    .o_valid    (valid),
    .o_frame_err(frame_err),
    .o_overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor and optional auto-ack two clocks after o_valid rises.
  always @(negedge clk) begin
    valid_prev <= valid;
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (overrun)   ov_cnt <= ov_cnt + 1;
    if (valid && !valid_prev) begin
      rise_cnt            <= rise_cnt + 1;
      rise_cyc            <= cyc;
      cap[rise_cnt % 16]  <= data;
    end
    if (!valid) begin
      vcnt     <= 0;
      ack_auto <= 1'b0;
    end else begin
      vcnt     <= vcnt + 1;
      ack_auto <= auto_en && (vcnt == 2);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Serialise one 8N1 frame; entered and left at posedge+1.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    start_cyc = cyc;
    wait_clks(Baud);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clks(Baud);
    end
    rx = stop_bit;
    wait_clks(Baud);
    rx = 1'b1;
  endtask

  task automatic do_ack(input string name);
    ack_man = 1'b1;
    chk({name, "_valid_before_ack_edge"}, {31'd0, valid}, 32'd1);
    wait_clks(1);
    ack_man = 1'b0;
    chk({name, "_valid_after_ack"}, {31'd0, valid}, 32'd0);
  endtask

  typedef struct {
    logic [7:0] tx_byte;
    logic       stop_bit;
    logic       ack_it;
    logic [7:0] exp_data;
    logic       exp_valid;
    int         exp_fe;
    int         exp_ov;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int fe0, ov0, r0;

    vecs[0] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 0, 0};
    vecs[1] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 0, 0};
    vecs[2] = '{8'h96, 1'b0, 1'b0, 8'hFF, 1'b0, 1, 0};
    vecs[3] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 0, 0};
    vecs[4] = '{8'h11, 1'b1, 1'b0, 8'h11, 1'b1, 0, 0};
    vecs[5] = '{8'h22, 1'b1, 1'b1, 8'h22, 1'b1, 0, 1};
    vecs[6] = '{8'hE7, 1'b1, 1'b1, 8'hE7, 1'b1, 0, 0};

    rst = 1'b0;
    rx = 1'b1;
    ack_man = 1'b0;
    wait_clks(3);
    chk("reset_data", {24'd0, data}, 32'd0);
    chk("reset_valid", {31'd0, valid}, 32'd0);
    chk("reset_ferr", {31'd0, frame_err}, 32'd0);
    chk("reset_ovr", {31'd0, overrun}, 32'd0);
    rst = 1'b1;
    wait_clks(4);

    // Single byte with exact latency and held valid.
    send_frame(8'h55, 1'b1);
    wait_clks(4);
    chk("single_latency", rise_cyc - start_cyc, 32'd79);
    chk("single_data", {24'd0, data}, 32'h55);
    wait_clks(20);
    chk("single_valid_held", {31'd0, valid}, 32'd1);
    do_ack("single");

    // Table-driven frames.
    for (int i = 0; i < 7; i++) begin
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      send_frame(vecs[i].tx_byte, vecs[i].stop_bit);
      wait_clks(6);
      chk($sformatf("vec%0d_data", i), {24'd0, data}, {24'd0, vecs[i].exp_data});
      chk($sformatf("vec%0d_valid", i), {31'd0, valid}, {31'd0, vecs[i].exp_valid});
      chk($sformatf("vec%0d_ferr", i), fe_cnt - fe0, vecs[i].exp_fe);
      chk($sformatf("vec%0d_ovr", i), ov_cnt - ov0, vecs[i].exp_ov);
      if (vecs[i].ack_it) do_ack($sformatf("vec%0d", i));
    end

    // Ack landing in the same cycle as a completing byte: new byte wins, no overrun.
    send_frame(8'h5A, 1'b1);
    wait_clks(4);
    chk("same_pre_valid", {31'd0, valid}, 32'd1);
    ov0 = ov_cnt;
    fork
      send_frame(8'hB4, 1'b1);
      begin
        wait_clks(78);
        ack_man = 1'b1;
        wait_clks(1);
        ack_man = 1'b0;
      end
    join
    wait_clks(4);
    chk("same_data", {24'd0, data}, 32'hB4);
    chk("same_valid", {31'd0, valid}, 32'd1);
    chk("same_ovr", ov_cnt - ov0, 0);
    do_ack("same");

    // Back-to-back frames with auto-ack.
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    r0 = rise_cnt;
    auto_en = 1'b1;
    send_frame(8'hA3, 1'b1);
    send_frame(8'h0F, 1'b1);
    wait_clks(10);
    auto_en = 1'b0;
    chk("b2b_count", rise_cnt - r0, 2);
    chk("b2b_byte0", {24'd0, cap[r0 % 16]}, 32'hA3);
    chk("b2b_byte1", {24'd0, cap[(r0 + 1) % 16]}, 32'h0F);
    chk("b2b_ferr", fe_cnt - fe0, 0);
    chk("b2b_ovr", ov_cnt - ov0, 0);
    chk("b2b_valid", {31'd0, valid}, 32'd0);

    // Glitch rejection.
    r0 = rise_cnt;
    rx = 1'b0;
    wait_clks(3);
    rx = 1'b1;
    wait_clks(2 * Baud * 10);
    chk("glitch_no_valid", rise_cnt - r0, 0);
    chk("glitch_valid", {31'd0, valid}, 32'd0);
    send_frame(8'h81, 1'b1);
    wait_clks(4);
    chk("glitch_next_data", {24'd0, data}, 32'h81);
    do_ack("glitch_next");

    // Break: line low for 12 bit periods.
    fe0 = fe_cnt;
    r0 = rise_cnt;
    rx = 1'b0;
    wait_clks(12 * Baud);
    rx = 1'b1;
    wait_clks(2 * Baud);
    chk("break_ferr_once", fe_cnt - fe0, 1);
    chk("break_no_valid", rise_cnt - r0, 0);
    chk("break_valid", {31'd0, valid}, 32'd0);
    send_frame(8'h3C, 1'b1);
    wait_clks(4);
    chk("break_next_data", {24'd0, data}, 32'h3C);
    chk("break_next_valid", {31'd0, valid}, 32'd1);

    // Reset during data bit 4 of 0xFF, with a byte still pending.
    rx = 1'b0;
    wait_clks(Baud);
    rx = 1'b1;
    wait_clks(4 * Baud + 4);
    rst = 1'b0;
    wait_clks(1);
    rst = 1'b1;
    chk("midrst_data", {24'd0, data}, 32'd0);
    chk("midrst_valid", {31'd0, valid}, 32'd0);
    chk("midrst_ferr", {31'd0, frame_err}, 32'd0);
    chk("midrst_ovr", {31'd0, overrun}, 32'd0);
    wait_clks(5 * Baud);
    send_frame(8'hC5, 1'b1);
    wait_clks(4);
    chk("midrst_next_data", {24'd0, data}, 32'hC5);
    chk("midrst_next_valid", {31'd0, valid}, 32'd1);
    do_ack("midrst_next");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver for 8N1 serial frames, the receive-side counterpart of the `tx` transmitter, sharing its `BAUD_DIV` clocks-per-bit convention. It synchronises the asynchronous `i_rx` line and detects the start bit with a false-start check. It samples each bit at mid-bit and delivers each byte through a valid/ack holding register. Framing and overrun errors are reported as single-cycle pulses.

## Interface
- `BAUD_DIV`, default 217: clocks per bit period. Legal range is 4..65535.
- `i_clk` in, 1 bit: clock.
- `i_rst` in, 1 bit: reset, synchronous, active-low.
- `i_rx` in, 1 bit: serial line, asynchronous, idle high.
- `i_ack` in, 1 bit: consumer accepts `o_data`. Ignored while `o_valid` is 0.
- `o_data` out, 8 bits: last received byte, LSB first on the wire.
- `o_valid` out, 1 bit: `o_data` holds an unaccepted byte. Level, held until acked.
- `o_frame_err` out, 1 bit: one-cycle pulse when a stop bit is sampled low.
- `o_overrun` out, 1 bit: one-cycle pulse when a completed byte overwrites an unaccepted one.

## Operation
- **Synchroniser:** 2-flop on `i_rx`, giving `rx_s`. All decisions use `rx_s`. Both flops reset to 1.
- **Counters:**
  - `baud_cnt` is 16-bit unsigned. It never wraps within the legal `BAUD_DIV` range.
  - `HALF` = `BAUD_DIV`/2, integer division.
  - `bit_cnt` is 4-bit and counts data bits received.
- **State machine:**
  - **IDLE:** if `rx_s`==0, load `baud_cnt`=1 and go to START. Otherwise stay.
  - **START:** if `baud_cnt`==`HALF`, sample `rx_s`. If it is 1 (glitch), go to IDLE. If it is 0, set `baud_cnt`=1 and `bit_cnt`=0, then go to DATA. Otherwise increment `baud_cnt`.
  - **DATA:** if `baud_cnt`==`BAUD_DIV`:
    - Shift `rx_s` into the shift register MSB (right shift, so the first bit ends at bit 0).
    - Increment `bit_cnt` and set `baud_cnt`=1.
    - After the 8th bit, go to STOP.
    - Otherwise increment `baud_cnt`.
  - **STOP:** if `baud_cnt`==`BAUD_DIV`, sample `rx_s`:
    - **1:** load `o_data` from the shift register, set `o_valid`=1, go to IDLE.
    - **0:** pulse `o_frame_err`. `o_data` and `o_valid` are unchanged. Go to WAIT_HIGH.
    - Otherwise increment `baud_cnt`.
  - **WAIT_HIGH:** stay until `rx_s`==1, then go to IDLE. This stops a break condition from being read as repeated frames.
  - **Undefined encodings:** go to IDLE.
- **Holding register:**
  - `i_ack` while `o_valid`=1 clears `o_valid` on the next edge.
  - A byte completing while `o_valid`=1 and `i_ack`=0 overwrites `o_data`, keeps `o_valid`=1, and pulses `o_overrun`.
  - A byte completing in the same cycle as `i_ack`: the new byte wins. `o_valid` stays 1 and there is no overrun.
- **Reset (`i_rst`=0 at a clock edge, at any time including mid-frame):**
  - State goes to IDLE, `o_data`=0, `o_valid`=0, `o_frame_err`=0, `o_overrun`=0.
  - The shift register, `baud_cnt` and `bit_cnt` are cleared.
  - A partial frame is discarded.

## Timing
- **Input latency:** `i_rx` falling edge to START entry is 3 clocks (2 synchroniser flops plus the IDLE registration).
- **Sample points:**
  - Start bit is sampled `HALF` clocks after START entry.
  - Data bit n is sampled `HALF`+(n+1)·`BAUD_DIV` clocks after START entry, n=0..7.
  - Stop bit is sampled `HALF`+9·`BAUD_DIV` clocks after START entry.
- **Output timing:** `o_valid`, `o_frame_err` and `o_overrun` are registered. They change on the edge following the stop-sample cycle.
- **Back-to-back frames:** the return to IDLE happens at mid-stop-bit. A next start edge immediately after the stop bit is therefore caught, and frames separated by only one stop bit are received.
- **Baud tolerance:** sampling is exact to ±1 clock relative to `tx` at the same `BAUD_DIV`, which is required to pass with 0 errors.
- **Handshake:** `o_valid` drops exactly 1 clock after the `i_ack` edge.

## Test plan
All scenarios use `BAUD_DIV`=8, with `i_rx` driven by a `tx` instance at `BAUD_DIV`=8 unless stated.
- **Single byte:** reset, then send 0x55 → `o_data`=0x55 and `o_valid`=1 about 80 clocks after the start edge. `o_valid` stays high until `i_ack`, then reads 0 one clock later.
- **Back-to-back:** send 0xA3 then 0x0F with no idle gap, acking each byte 2 clocks after `o_valid` rises → two valid bytes 0xA3 and 0x0F, with `o_frame_err`=`o_overrun`=0 throughout.
- **Glitch rejection:** drive `i_rx` low for 3 clocks, then high → no `o_valid`, and state returns to IDLE. A following 0x81 frame is received correctly.
- **Framing error:** hold `i_rx` low for 12 bit periods, then high → exactly one `o_frame_err` pulse and `o_valid` stays 0. A following 0x3C frame is received correctly.
- **Overrun:** send 0x11 then 0x22 with no ack → one `o_overrun` pulse at the second completion, `o_data`=0x22, `o_valid`=1.
- **Reset mid-frame:** assert `i_rst`=0 for 1 clock during data bit 4 of 0xFF → all outputs 0. A subsequent 0xC5 frame is received with `o_data`=0xC5.
